// File: rtl/maxnet_pkg.sv
// Shared constants and state encoding for the MaxNet weight store.
package maxnet_pkg;

   localparam logic [31:0] FP_ONE               = 32'h3F80_0000;
   localparam logic [31:0] FP_MINUS_EPS_DEFAULT = 32'hBE4C_CCCD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Index width that never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weight_matrix_buffer_if.sv
// Control, write and row-read handshake bundle between the neuron datapath and the weight store.
interface weight_matrix_buffer_if
   import maxnet_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 32
);
   localparam int IW = idx_w(N);

   logic              init;
   logic [DW-1:0]     eps_in;
   logic              wr_en;
   logic [IW-1:0]     wr_row;
   logic [IW-1:0]     wr_col;
   logic [DW-1:0]     wr_data;
   logic              rd_req;
   logic [IW-1:0]     rd_row;
   logic              out_valid;
   logic              out_ready;
   logic [N*DW-1:0]   out_data;
   logic              busy;

   modport master (
      output init, eps_in, wr_en, wr_row, wr_col, wr_data, rd_req, rd_row, out_ready,
      input  out_valid, out_data, busy
   );

   modport slave (
      input  init, eps_in, wr_en, wr_row, wr_col, wr_data, rd_req, rd_row, out_ready,
      output out_valid, out_data, busy
   );

endinterface

// File: rtl/weight_row_gen.sv
// Default MaxNet row: ONE on the diagonal column, eps everywhere else.
module weight_row_gen
   import maxnet_pkg::*;
#(
   parameter int          N   = 4,
   parameter int          DW  = 32,
   parameter logic [DW-1:0] ONE = FP_ONE,
   parameter int          IW  = idx_w(N)
) (
   input  logic [IW-1:0]   row,
   input  logic [DW-1:0]   eps,
   output logic [N*DW-1:0] row_data
);

   always_comb begin
      row_data = '0;
      for (int c = 0; c < N; c++) begin
         row_data[c*DW +: DW] = (int'(row) == c) ? ONE : eps;
      end
   end

endmodule

// File: rtl/weight_matrix_buffer.sv
// NxN MaxNet weight store with run-time re-init, single-entry writes and row reads.
// Define SYMMETRIC_WRITE_EN to mirror every write into W[col][row].
module weight_matrix_buffer
   import maxnet_pkg::*;
#(
   parameter int            N    = 4,
   parameter int            DW   = 32,
   parameter logic [DW-1:0] ONE  = FP_ONE,
   parameter logic [DW-1:0] MEPS = FP_MINUS_EPS_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   weight_matrix_buffer_if.slave bus
);

   localparam int IW = idx_w(N);
   localparam int AW = idx_w(N * N);

`ifdef SYMMETRIC_WRITE_EN
   localparam bit SYM_WR = 1'b1;
`else
   localparam bit SYM_WR = 1'b0;
`endif

   state_t          state;
   logic [IW-1:0]   init_cnt;
   logic [DW-1:0]   eps_r;
   logic            out_valid_r;
   logic [N*DW-1:0] out_data_r;
   logic            busy_r;
   logic [DW-1:0]   w [0:N*N-1];

   logic [N*DW-1:0] init_row;
   logic [N*DW-1:0] rd_vec;
   logic [N*DW-1:0] rst_rows [0:N-1];
   logic            wr_ok;
   logic            wr_accept;
   logic            hs;

   function automatic logic in_range(input logic [IW-1:0] v);
      return int'(v) < N;
   endfunction

   function automatic logic [AW-1:0] widx(input logic [IW-1:0] r, input logic [IW-1:0] c);
      return AW'(int'(r) * N + int'(c));
   endfunction

   for (genvar i = 0; i < N; i++) begin : g_rst
      weight_row_gen #(.N(N), .DW(DW), .ONE(ONE), .IW(IW)) u_rst_row (
         .row      (IW'(i)),
         .eps      (MEPS),
         .row_data (rst_rows[i])
      );
   end

   weight_row_gen #(.N(N), .DW(DW), .ONE(ONE), .IW(IW)) u_init_row (
      .row      (init_cnt),
      .eps      (eps_r),
      .row_data (init_row)
   );

   // Out-of-range rows read back as zero but still complete the handshake.
   always_comb begin
      rd_vec = '0;
      if (in_range(bus.rd_row)) begin
         for (int c = 0; c < N; c++) begin
            rd_vec[c*DW +: DW] = w[widx(bus.rd_row, IW'(c))];
         end
      end
   end

   assign wr_ok     = bus.wr_en && in_range(bus.wr_row) && in_range(bus.wr_col);
   assign wr_accept = wr_ok && (((state == IDLE) && !bus.init) || (state == OUT));
   assign hs        = out_valid_r && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         init_cnt    <= '0;
         eps_r       <= MEPS;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         busy_r      <= 1'b0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               w[widx(IW'(i), IW'(j))] <= rst_rows[i][j*DW +: DW];
            end
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.init) begin
                  eps_r    <= bus.eps_in;
                  init_cnt <= '0;
                  busy_r   <= 1'b1;
                  state    <= INIT;
               end else if (bus.rd_req) begin
                  out_data_r  <= rd_vec;
                  out_valid_r <= 1'b1;
                  state       <= OUT;
               end
            end
            INIT: begin
               for (int c = 0; c < N; c++) begin
                  w[widx(init_cnt, IW'(c))] <= init_row[c*DW +: DW];
               end
               if (init_cnt == IW'(N - 1)) begin
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            OUT: begin
               if (hs) begin
                  if (bus.rd_req) begin
                     out_data_r <= rd_vec;
                  end else begin
                     out_valid_r <= 1'b0;
                     state       <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Reads above sample rd_vec before these writes land, giving pre-write data.
         if (wr_accept) begin
            w[widx(bus.wr_row, bus.wr_col)] <= bus.wr_data;
            if (SYM_WR) begin
               w[widx(bus.wr_col, bus.wr_row)] <= bus.wr_data;
            end
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_weight_matrix_buffer.sv
// Scoreboard bench for weight_matrix_buffer at N=4; honours SYMMETRIC_WRITE_EN when defined.
module tb_weight_matrix_buffer;

   localparam int          N    = 4;
   localparam int          DW   = 32;
   localparam logic [31:0] ONE  = 32'h3F80_0000;
   localparam logic [31:0] MEPS = 32'hBE4C_CCCD;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [N*DW-1:0] sb [$];
   logic [DW-1:0]   ref_w [0:N*N-1];

   weight_matrix_buffer_if #(.N(N), .DW(DW)) bus ();

   weight_matrix_buffer #(.N(N), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Scoreboard: every accepted row must match the oldest expected row.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_row got=%h expected none", bus.out_data);
         end else begin
            logic [N*DW-1:0] exp_row;
            exp_row = sb.pop_front();
            if (bus.out_data !== exp_row) begin
               errors++;
               $display("FAIL sb_row got=%h expected=%h", bus.out_data, exp_row);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.init      = 1'b0;
      bus.eps_in    = '0;
      bus.wr_en     = 1'b0;
      bus.wr_row    = '0;
      bus.wr_col    = '0;
      bus.wr_data   = '0;
      bus.rd_req    = 1'b0;
      bus.rd_row    = '0;
      bus.out_ready = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            ref_w[i*N+j] = (i == j) ? ONE : MEPS;
   endtask

   task automatic model_init(input logic [31:0] eps);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            ref_w[i*N+j] = (i == j) ? ONE : eps;
   endtask

   task automatic model_write(input int r, input int c, input logic [31:0] d);
      ref_w[r*N+c] = d;
`ifdef SYMMETRIC_WRITE_EN
      ref_w[c*N+r] = d;
`endif
   endtask

   function automatic logic [N*DW-1:0] model_row(input int r);
      logic [N*DW-1:0] v;
      for (int c = 0; c < N; c++) v[c*DW +: DW] = ref_w[r*N+c];
      return v;
   endfunction

   task automatic read_row(input int r, output logic [N*DW-1:0] got);
      bus.rd_req    = 1'b1;
      bus.rd_row    = 2'(r);
      bus.out_ready = 1'b1;
      sb.push_back(model_row(r));
      step();
      bus.rd_req = 1'b0;
      got = bus.out_data;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      step();
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b expected=0", bus.out_valid); end
      checks++;
      if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h expected=0", bus.out_data); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", bus.busy); end
      model_reset();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_read_latency();
      bus.rd_req    = 1'b1;
      bus.rd_row    = 2'd2;
      bus.out_ready = 1'b1;
      sb.push_back(model_row(2));
      step();
      bus.rd_req = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL read_latency_valid got=%b expected=1", bus.out_valid); end
      checks++;
      if (bus.out_data !== {MEPS, ONE, MEPS, MEPS}) begin
         errors++; $display("FAIL read_row2_reset got=%h expected=%h", bus.out_data, {MEPS, ONE, MEPS, MEPS});
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL read_release_valid got=%b expected=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      bus.rd_req    = 1'b1;
      bus.rd_row    = 2'd0;
      bus.out_ready = 1'b1;
      sb.push_back(model_row(0));
      for (int r = 1; r < N; r++) begin
         step();
         checks++;
         if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d got=%b expected=1", r, bus.out_valid); end
         bus.rd_row = 2'(r);
         sb.push_back(model_row(r));
      end
      step();
      bus.rd_req = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_last_valid got=%b expected=1", bus.out_valid); end
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b expected=0", bus.out_valid); end
   endtask

   task automatic test_read_write_same_cycle();
      logic [N*DW-1:0] got;
      bus.rd_req    = 1'b1;
      bus.rd_row    = 2'd1;
      bus.out_ready = 1'b1;
      bus.wr_en     = 1'b1;
      bus.wr_row    = 2'd1;
      bus.wr_col    = 2'd2;
      bus.wr_data   = 32'h3F00_0000;
      sb.push_back(model_row(1));
      model_write(1, 2, 32'h3F00_0000);
      step();
      bus.rd_req = 1'b0;
      bus.wr_en  = 1'b0;
      checks++;
      if (bus.out_data[2*DW +: DW] !== MEPS) begin
         errors++; $display("FAIL rw_pre_write got=%h expected=%h", bus.out_data[2*DW +: DW], MEPS);
      end
      step();
      read_row(1, got);
      checks++;
      if (got[2*DW +: DW] !== 32'h3F00_0000) begin
         errors++; $display("FAIL rw_post_write got=%h expected=3f000000", got[2*DW +: DW]);
      end
   endtask

   task automatic test_symmetric_write();
      logic [N*DW-1:0] got;
      logic [31:0]     exp_c0;
`ifdef SYMMETRIC_WRITE_EN
      exp_c0 = 32'h4040_0000;
`else
      exp_c0 = MEPS;
`endif
      bus.wr_en   = 1'b1;
      bus.wr_row  = 2'd0;
      bus.wr_col  = 2'd2;
      bus.wr_data = 32'h4040_0000;
      model_write(0, 2, 32'h4040_0000);
      step();
      bus.wr_en = 1'b0;
      read_row(2, got);
      checks++;
      if (got[0 +: DW] !== exp_c0) begin errors++; $display("FAIL sym_w20 got=%h expected=%h", got[0 +: DW], exp_c0); end
      read_row(0, got);
      checks++;
      if (got[2*DW +: DW] !== 32'h4040_0000) begin
         errors++; $display("FAIL sym_w02 got=%h expected=40400000", got[2*DW +: DW]);
      end
   endtask

   task automatic test_stall_snapshot();
      logic [N*DW-1:0] snap;
      logic [N*DW-1:0] got;
      bus.rd_req    = 1'b1;
      bus.rd_row    = 2'd3;
      bus.out_ready = 1'b0;
      snap = model_row(3);
      sb.push_back(snap);
      step();
      bus.rd_req  = 1'b0;
      bus.wr_en   = 1'b1;
      bus.wr_row  = 2'd3;
      bus.wr_col  = 2'd0;
      bus.wr_data = 32'h4100_0000;
      model_write(3, 0, 32'h4100_0000);
      step();
      bus.wr_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== snap) begin
            errors++; $display("FAIL stall_hold_%0d got=%b/%h expected=1/%h", k, bus.out_valid, bus.out_data, snap);
         end
         if (k < 4) step();
      end
      bus.out_ready = 1'b1;
      step();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got=%b expected=0", bus.out_valid); end
      read_row(3, got);
      checks++;
      if (got[0 +: DW] !== 32'h4100_0000) begin
         errors++; $display("FAIL stall_readback got=%h expected=41000000", got[0 +: DW]);
      end
   endtask

   task automatic wait_busy(input string name, input int expected_cycles);
      int n = 0;
      while (bus.busy === 1'b1 && n < 20) begin
         n++;
         step();
      end
      checks++;
      if (n != expected_cycles) begin errors++; $display("FAIL %s_busy_cycles got=%0d expected=%0d", name, n, expected_cycles); end
   endtask

   task automatic test_init();
      logic [N*DW-1:0] got;
      logic [31:0]     eps;
      eps = 32'hBDCC_CCCD;
      bus.init   = 1'b1;
      bus.eps_in = eps;
      step();
      bus.init = 1'b0;
      wait_busy("init", N);
      model_init(eps);
      read_row(0, got);
      checks++;
      if (got !== {eps, eps, eps, ONE}) begin errors++; $display("FAIL init_row0 got=%h expected=%h", got, {eps, eps, eps, ONE}); end
   endtask

   task automatic test_init_priority();
      logic [N*DW-1:0] got;
      logic [31:0]     eps;
      eps = 32'hBE00_0000;
      bus.init      = 1'b1;
      bus.eps_in    = eps;
      bus.wr_en     = 1'b1;
      bus.wr_row    = 2'd1;
      bus.wr_col    = 2'd3;
      bus.wr_data   = 32'h4000_0000;
      bus.rd_req    = 1'b1;
      bus.rd_row    = 2'd0;
      bus.out_ready = 1'b1;
      step();
      bus.init    = 1'b0;
      bus.wr_row  = 2'd2;
      bus.wr_col  = 2'd1;
      bus.wr_data = 32'h4080_0000;
      bus.rd_row  = 2'd2;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL prio_read_ignored got=%b expected=0", bus.out_valid); end
      step();
      bus.wr_en  = 1'b0;
      bus.rd_req = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL init_read_ignored got=%b expected=0", bus.out_valid); end
      wait_busy("prio", N - 1);
      model_init(eps);
      read_row(1, got);
      checks++;
      if (got[3*DW +: DW] !== eps) begin errors++; $display("FAIL prio_w13 got=%h expected=%h", got[3*DW +: DW], eps); end
      read_row(2, got);
      checks++;
      if (got[1*DW +: DW] !== eps) begin errors++; $display("FAIL init_w21 got=%h expected=%h", got[1*DW +: DW], eps); end
   endtask

   task automatic test_reset_mid_init();
      logic [N*DW-1:0] got;
      bus.init   = 1'b1;
      bus.eps_in = 32'hBF00_0000;
      step();
      bus.init = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL midinit_busy got=%b expected=0", bus.busy); end
      step();
      rst_n = 1'b1;
      model_reset();
      step();
      read_row(0, got);
      checks++;
      if (got !== {MEPS, MEPS, MEPS, ONE}) begin errors++; $display("FAIL midinit_row0 got=%h expected=%h", got, {MEPS, MEPS, MEPS, ONE}); end
      read_row(3, got);
      checks++;
      if (got !== {ONE, MEPS, MEPS, MEPS}) begin errors++; $display("FAIL midinit_row3 got=%h expected=%h", got, {ONE, MEPS, MEPS, MEPS}); end
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_back_to_back();
      test_read_write_same_cycle();
      test_symmetric_write();
      test_stall_snapshot();
      test_init();
      test_init_priority();
      test_reset_mid_init();
      step();
      step();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d expected=0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
